// File: rtl/sdram_wb_arb_pkg.sv
// Shared types and helpers for the SDRAM Wishbone arbiter.
//   arb_state_t : arbiter FSM encoding (IDLE / BUSY / GAP)
//   CTI_*       : Wishbone cycle-type codes seen on m_cti_i / wb_cti_o
//   next_rr()   : round-robin scan returning {valid, winner index}
package sdram_wb_arb_pkg;

  localparam int unsigned MAX_MASTERS = 8;
  localparam int unsigned IDX_W       = 3;

  typedef enum logic [1:0] {IDLE, BUSY, GAP} arb_state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Scan ptr+1 .. ptr+n (mod n) and return the first requester.
  // Bit IDX_W of the result is the valid flag; the low bits are the index.
  function automatic logic [IDX_W:0] next_rr(input logic [MAX_MASTERS-1:0] req,
                                             input logic [IDX_W-1:0]       ptr,
                                             input int unsigned            n);
    logic [IDX_W:0] res;
    int unsigned    idx;
    res = '0;
    for (int unsigned i = 1; i <= MAX_MASTERS; i++) begin
      idx = (32'(ptr) + i) % n;
      if (i <= n && !res[IDX_W] && req[idx[IDX_W-1:0]])
        res = {1'b1, idx[IDX_W-1:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector.
//   req    : per-master request vector
//   rr_ptr : index of the most recently granted master
//   winner : index of the selected master (valid only when valid = 1)
//   valid  : at least one request present
module rr_picker
  import sdram_wb_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       rr_ptr,
  output logic [IDX_W-1:0]       winner,
  output logic                   valid
);

  logic [MAX_MASTERS-1:0] req_pad;
  logic [IDX_W:0]         pick;

  always_comb begin
    req_pad = MAX_MASTERS'(req);
    pick    = next_rr(req_pad, rr_ptr, NUM_MASTERS);
    valid   = pick[IDX_W];
    winner  = pick[IDX_W-1:0];
  end

endmodule

// File: rtl/sdram_wb_arbiter.sv
// Round-robin Wishbone arbiter in front of the SDRAM controller's slave port.
// A grant is held for a whole WB cycle (until the owner drops cyc), followed by
// a one-cycle GAP turnaround. No grant is issued before sdr_init_done.
//
// Ports:
//   sys_clk, RESETN         : clock, asynchronous active-low reset
//   sdr_init_done           : SDRAM initialisation complete (gates new grants)
//   m_*_i                   : packed per-master Wishbone master signals
//   m_ack_o, m_dat_o        : per-master ack, broadcast read data
//   wb_*_o / wb_ack_i/dat_i : Wishbone port to the SDRAM controller
//   grant_o                 : one-hot current grant (zero unless BUSY)
//   busy_o                  : arbiter in BUSY
//   m_err_o                 : per-master timeout error pulse (optional)
//
// Optional feature: define SDRAM_WB_ARB_TIMEOUT_EN to add m_err_o and a
// watchdog that abandons a cycle after TIMEOUT_CYCLES stalled strobe cycles.
module sdram_wb_arbiter
  import sdram_wb_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned DW             = 32,
  parameter int unsigned AW             = 26,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                            sys_clk,
  input  logic                            RESETN,
  input  logic                            sdr_init_done,
  input  logic [NUM_MASTERS-1:0]          m_cyc_i,
  input  logic [NUM_MASTERS-1:0]          m_stb_i,
  input  logic [NUM_MASTERS-1:0]          m_we_i,
  input  logic [NUM_MASTERS*AW-1:0]       m_addr_i,
  input  logic [NUM_MASTERS*DW-1:0]       m_dat_i,
  input  logic [NUM_MASTERS*(DW/8)-1:0]   m_sel_i,
  input  logic [NUM_MASTERS*3-1:0]        m_cti_i,
  output logic [NUM_MASTERS-1:0]          m_ack_o,
  output logic [DW-1:0]                   m_dat_o,
  output logic                            wb_cyc_o,
  output logic                            wb_stb_o,
  output logic                            wb_we_o,
  output logic [AW-1:0]                   wb_addr_o,
  output logic [DW-1:0]                   wb_dat_o,
  output logic [DW/8-1:0]                 wb_sel_o,
  output logic [2:0]                      wb_cti_o,
  input  logic                            wb_ack_i,
  input  logic [DW-1:0]                   wb_dat_i,
  output logic [NUM_MASTERS-1:0]          grant_o,
  output logic                            busy_o
`ifdef SDRAM_WB_ARB_TIMEOUT_EN
  ,
  output logic [NUM_MASTERS-1:0]          m_err_o
`endif
);

  localparam int unsigned SW = DW / 8;

  if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS || TIMEOUT_CYCLES < 2 || (DW % 8) != 0)
  begin : g_cfg_err
    $error("sdram_wb_arbiter: unsupported parameter set");
  end

  arb_state_t             state, state_d;
  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [NUM_MASTERS-1:0] pick_oh;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;
  logic                   to_hit;

  // Selected master's signals (AND-OR mux on the registered one-hot grant)
  logic                   sel_cyc, sel_stb, sel_we;
  logic [AW-1:0]          sel_addr;
  logic [DW-1:0]          sel_dat;
  logic [SW-1:0]          sel_sel;
  logic [2:0]             sel_cti;

  assign req = m_cyc_i & m_stb_i;

  rr_picker #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  always_comb begin
    for (int unsigned k = 0; k < NUM_MASTERS; k++)
      pick_oh[k] = (pick_idx == IDX_W'(k));
  end

  always_comb begin
    sel_cyc  = 1'b0;
    sel_stb  = 1'b0;
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_dat  = '0;
    sel_sel  = '0;
    sel_cti  = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      if (grant_q[k]) begin
        sel_cyc  = m_cyc_i[k];
        sel_stb  = m_stb_i[k];
        sel_we   = m_we_i[k];
        sel_addr = m_addr_i[k*AW +: AW];
        sel_dat  = m_dat_i[k*DW +: DW];
        sel_sel  = m_sel_i[k*SW +: SW];
        sel_cti  = m_cti_i[k*3 +: 3];
      end
    end
  end

`ifdef SDRAM_WB_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  // Fires on the TIMEOUT_CYCLES-th consecutive stalled strobe cycle
  assign to_hit = (state == BUSY) && sel_stb && !wb_ack_i &&
                  (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge sys_clk or negedge RESETN) begin
    if (!RESETN)
      to_cnt <= '0;
    else if (state != BUSY || wb_ack_i)
      to_cnt <= '0;
    else if (sel_stb)
      to_cnt <= to_cnt + TW'(1);
  end
`else
  assign to_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge sys_clk or negedge RESETN) begin
    if (!RESETN)
      state <= IDLE;
    else
      state <= state_d;
  end

  // Grant and round-robin pointer; pointer reset makes master 0 first
  always_ff @(posedge sys_clk or negedge RESETN) begin
    if (!RESETN) begin
      grant_q <= '0;
      rr_ptr  <= IDX_W'(NUM_MASTERS - 1);
    end else if (state == IDLE && state_d == BUSY) begin
      grant_q <= pick_oh;
      rr_ptr  <= pick_idx;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (sdr_init_done && pick_valid) state_d = BUSY;
      BUSY:    if (!sel_cyc || to_hit)          state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: everything is zero outside BUSY, so stray acks never propagate
  always_comb begin
    wb_cyc_o  = 1'b0;
    wb_stb_o  = 1'b0;
    wb_we_o   = 1'b0;
    wb_addr_o = '0;
    wb_dat_o  = '0;
    wb_sel_o  = '0;
    wb_cti_o  = '0;
    m_ack_o   = '0;
    m_dat_o   = '0;
    grant_o   = '0;
    busy_o    = 1'b0;
`ifdef SDRAM_WB_ARB_TIMEOUT_EN
    m_err_o   = '0;
`endif
    if (state == BUSY) begin
      busy_o    = 1'b1;
      grant_o   = grant_q;
      wb_cyc_o  = sel_cyc;
      wb_stb_o  = sel_stb;
      wb_we_o   = sel_we;
      wb_addr_o = sel_addr;
      wb_dat_o  = sel_dat;
      wb_sel_o  = sel_sel;
      wb_cti_o  = sel_cti;
      m_ack_o   = grant_q & {NUM_MASTERS{wb_ack_i}};
      m_dat_o   = wb_dat_i;
`ifdef SDRAM_WB_ARB_TIMEOUT_EN
      if (to_hit) begin
        wb_cyc_o = 1'b0;
        wb_stb_o = 1'b0;
        m_err_o  = grant_q;
      end
`endif
    end
  end

endmodule

// File: tb/tb_sdram_wb_arbiter.sv
module tb_sdram_wb_arbiter;
  import sdram_wb_arb_pkg::*;

  localparam int unsigned NM = 2;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 26;
  localparam int unsigned SW = DW / 8;

  localparam logic [AW-1:0] A0 = 26'h010;
  localparam logic [AW-1:0] A1 = 26'h020;
  localparam logic [DW-1:0] D0 = 32'hDEADBEEF;
  localparam logic [DW-1:0] D1 = 32'h11111111;
  localparam logic [DW-1:0] RD = 32'hCAFEF00D;

  logic                 sys_clk, RESETN, sdr_init_done;
  logic [NM-1:0]        m_cyc_i, m_stb_i, m_we_i;
  logic [NM*AW-1:0]     m_addr_i;
  logic [NM*DW-1:0]     m_dat_i;
  logic [NM*SW-1:0]     m_sel_i;
  logic [NM*3-1:0]      m_cti_i;
  logic [NM-1:0]        m_ack_o;
  logic [DW-1:0]        m_dat_o;
  logic                 wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW-1:0]        wb_addr_o;
  logic [DW-1:0]        wb_dat_o;
  logic [SW-1:0]        wb_sel_o;
  logic [2:0]           wb_cti_o;
  logic                 wb_ack_i;
  logic [DW-1:0]        wb_dat_i;
  logic [NM-1:0]        grant_o;
  logic                 busy_o;
`ifdef SDRAM_WB_ARB_TIMEOUT_EN
  logic [NM-1:0]        m_err_o;
`endif

  logic [2:0] m1_cti;

  assign m_addr_i = {A1, A0};
  assign m_dat_i  = {D1, D0};
  assign m_sel_i  = {4'h3, 4'hF};
  assign m_we_i   = 2'b01;
  assign m_cti_i  = {m1_cti, CTI_CLASSIC};

  sdram_wb_arbiter #(
    .NUM_MASTERS    (NM),
    .DW             (DW),
    .AW             (AW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .sys_clk       (sys_clk),
    .RESETN        (RESETN),
    .sdr_init_done (sdr_init_done),
    .m_cyc_i       (m_cyc_i),
    .m_stb_i       (m_stb_i),
    .m_we_i        (m_we_i),
    .m_addr_i      (m_addr_i),
    .m_dat_i       (m_dat_i),
    .m_sel_i       (m_sel_i),
    .m_cti_i       (m_cti_i),
    .m_ack_o       (m_ack_o),
    .m_dat_o       (m_dat_o),
    .wb_cyc_o      (wb_cyc_o),
    .wb_stb_o      (wb_stb_o),
    .wb_we_o       (wb_we_o),
    .wb_addr_o     (wb_addr_o),
    .wb_dat_o      (wb_dat_o),
    .wb_sel_o      (wb_sel_o),
    .wb_cti_o      (wb_cti_o),
    .wb_ack_i      (wb_ack_i),
    .wb_dat_i      (wb_dat_i),
    .grant_o       (grant_o),
    .busy_o        (busy_o)
`ifdef SDRAM_WB_ARB_TIMEOUT_EN
    ,
    .m_err_o       (m_err_o)
`endif
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected slave-side fields given the expected grant
  function automatic logic [AW-1:0] e_addr(input logic [1:0] g);
    return (g == 2'b01) ? A0 : (g == 2'b10) ? A1 : '0;
  endfunction
  function automatic logic [DW-1:0] e_dat(input logic [1:0] g);
    return (g == 2'b01) ? D0 : (g == 2'b10) ? D1 : '0;
  endfunction
  function automatic logic [SW-1:0] e_sel(input logic [1:0] g);
    return (g == 2'b01) ? 4'hF : (g == 2'b10) ? 4'h3 : 4'h0;
  endfunction

  typedef struct packed {
    logic       init;
    logic [1:0] cyc;
    logic [1:0] stb;
    logic       ack;
    logic [1:0] e_grant;
    logic       e_stb;
    logic [1:0] e_ack;
    logic       e_busy;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  initial begin
    // init cyc    stb    ack   grant  stb   ack    busy
    vecs[0]  = '{1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0}; // idle
    vecs[1]  = '{1'b1, 2'b01, 2'b01, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0}; // m0 req sampled
    vecs[2]  = '{1'b1, 2'b01, 2'b01, 1'b0, 2'b01, 1'b1, 2'b00, 1'b1}; // stb 1 cycle later
    vecs[3]  = '{1'b1, 2'b01, 2'b01, 1'b1, 2'b01, 1'b1, 2'b01, 1'b1}; // ack -> m0
    vecs[4]  = '{1'b1, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 2'b00, 1'b1}; // m0 drops cyc
    vecs[5]  = '{1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0}; // GAP
    vecs[6]  = '{1'b1, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0}; // stray ack in IDLE
    vecs[7]  = '{1'b1, 2'b11, 2'b11, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0}; // both request
    vecs[8]  = '{1'b1, 2'b11, 2'b11, 1'b1, 2'b10, 1'b1, 2'b10, 1'b1}; // m1 wins
    vecs[9]  = '{1'b1, 2'b01, 2'b01, 1'b0, 2'b10, 1'b0, 2'b00, 1'b1}; // m1 drops
    vecs[10] = '{1'b1, 2'b11, 2'b11, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0}; // GAP
    vecs[11] = '{1'b1, 2'b11, 2'b11, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0}; // IDLE arbitration
    vecs[12] = '{1'b1, 2'b11, 2'b11, 1'b1, 2'b01, 1'b1, 2'b01, 1'b1}; // m0 wins
    vecs[13] = '{1'b1, 2'b10, 2'b10, 1'b0, 2'b01, 1'b0, 2'b00, 1'b1}; // m0 drops
    vecs[14] = '{1'b1, 2'b11, 2'b11, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0}; // GAP
    vecs[15] = '{1'b1, 2'b11, 2'b11, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0}; // IDLE
    vecs[16] = '{1'b1, 2'b11, 2'b11, 1'b1, 2'b10, 1'b1, 2'b10, 1'b1}; // m1 wins
    vecs[17] = '{1'b1, 2'b01, 2'b01, 1'b0, 2'b10, 1'b0, 2'b00, 1'b1}; // m1 drops
    vecs[18] = '{1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0}; // GAP
    vecs[19] = '{1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0}; // IDLE
    vecs[20] = '{1'b1, 2'b01, 2'b01, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0}; // m0 req
    vecs[21] = '{1'b1, 2'b00, 2'b00, 1'b1, 2'b01, 1'b0, 2'b01, 1'b1}; // ack + cyc drop together
    vecs[22] = '{1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0}; // GAP
    vecs[23] = '{1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0}; // IDLE
  end

  task automatic check_all_zero(input string tag);
    check({tag, " grant"},  64'(grant_o),   64'(0));
    check({tag, " busy"},   64'(busy_o),    64'(0));
    check({tag, " wb_cyc"}, 64'(wb_cyc_o),  64'(0));
    check({tag, " wb_stb"}, 64'(wb_stb_o),  64'(0));
    check({tag, " wb_we"},  64'(wb_we_o),   64'(0));
    check({tag, " addr"},   64'(wb_addr_o), 64'(0));
    check({tag, " m_ack"},  64'(m_ack_o),   64'(0));
    check({tag, " m_dat"},  64'(m_dat_o),   64'(0));
  endtask

  initial begin
    RESETN        = 1'b0;
    sdr_init_done = 1'b0;
    m_cyc_i       = '0;
    m_stb_i       = '0;
    wb_ack_i      = 1'b0;
    wb_dat_i      = RD;
    m1_cti        = CTI_INCR;

    // Reset state (read data present on the bus must not leak through)
    repeat (2) @(negedge sys_clk);
    #1 check_all_zero("reset");
    @(negedge sys_clk);
    RESETN = 1'b1;

    // Table-driven vectors: drive after negedge, check 1 time unit later
    for (int i = 0; i < NV; i++) begin
      @(negedge sys_clk);
      sdr_init_done = vecs[i].init;
      m_cyc_i       = vecs[i].cyc;
      m_stb_i       = vecs[i].stb;
      wb_ack_i      = vecs[i].ack;
      #1;
      check($sformatf("v%0d grant", i),  64'(grant_o),   64'(vecs[i].e_grant));
      check($sformatf("v%0d wb_stb", i), 64'(wb_stb_o),  64'(vecs[i].e_stb));
      check($sformatf("v%0d wb_cyc", i), 64'(wb_cyc_o),  64'(vecs[i].e_stb));
      check($sformatf("v%0d m_ack", i),  64'(m_ack_o),   64'(vecs[i].e_ack));
      check($sformatf("v%0d busy", i),   64'(busy_o),    64'(vecs[i].e_busy));
      check($sformatf("v%0d addr", i),   64'(wb_addr_o), 64'(e_addr(vecs[i].e_grant)));
      check($sformatf("v%0d wdat", i),   64'(wb_dat_o),  64'(e_dat(vecs[i].e_grant)));
      check($sformatf("v%0d sel", i),    64'(wb_sel_o),  64'(e_sel(vecs[i].e_grant)));
      check($sformatf("v%0d we", i),     64'(wb_we_o),   64'(vecs[i].e_grant == 2'b01));
      check($sformatf("v%0d rdat", i),   64'(m_dat_o),   64'(vecs[i].e_busy ? RD : 32'h0));
    end

    // Burst hold: m1 wins (m1 last lost), 4 beats while m0 keeps requesting
    @(negedge sys_clk);
    m_cyc_i = 2'b11;
    m_stb_i = 2'b11;
    #1 check("burst arb grant", 64'(grant_o), 64'(0));
    for (int b = 0; b < 4; b++) begin
      @(negedge sys_clk);
      m1_cti   = (b == 3) ? CTI_EOB : CTI_INCR;
      wb_ack_i = 1'b1;
      wb_dat_i = 32'h1000 + 32'(b);
      #1;
      check($sformatf("burst b%0d grant", b), 64'(grant_o),  64'(2'b10));
      check($sformatf("burst b%0d ack", b),   64'(m_ack_o),  64'(2'b10));
      check($sformatf("burst b%0d cti", b),   64'(wb_cti_o), 64'((b == 3) ? 3'b111 : 3'b010));
      check($sformatf("burst b%0d rdat", b),  64'(m_dat_o),  64'(32'h1000 + 32'(b)));
    end
    @(negedge sys_clk);
    m_cyc_i  = 2'b01;
    m_stb_i  = 2'b01;
    wb_ack_i = 1'b0;
    wb_dat_i = RD;
    #1 check("burst drop grant", 64'(grant_o), 64'(2'b10));
    @(negedge sys_clk);
    #1 check("burst gap grant", 64'(grant_o), 64'(0));
    @(negedge sys_clk);
    #1 check("burst idle grant", 64'(grant_o), 64'(0));
    @(negedge sys_clk);
    #1 check("burst m0 grant", 64'(grant_o), 64'(2'b01));
    m_cyc_i = 2'b00;
    m_stb_i = 2'b00;
    repeat (2) @(negedge sys_clk);

    // Init gating: m1 requests for 50 cycles with init low
    sdr_init_done = 1'b0;
    m_cyc_i = 2'b10;
    m_stb_i = 2'b10;
    for (int c = 0; c < 50; c++) begin
      @(negedge sys_clk);
      #1 check($sformatf("gate c%0d grant/stb", c), 64'({grant_o, wb_stb_o}), 64'(0));
    end
    sdr_init_done = 1'b1;
    #1 check("gate rise grant", 64'(grant_o), 64'(0));
    @(negedge sys_clk);
    #1 check("gate granted", 64'(grant_o), 64'(2'b10));

    // Init falls while BUSY: cycle completes, no new grant until it rises
    sdr_init_done = 1'b0;
    wb_ack_i = 1'b1;
    @(negedge sys_clk);
    #1 check("initfall grant", 64'(grant_o), 64'(2'b10));
    check("initfall ack", 64'(m_ack_o), 64'(2'b10));
    wb_ack_i = 1'b0;
    m_cyc_i  = 2'b01;
    m_stb_i  = 2'b01;
    for (int c = 0; c < 6; c++) begin
      @(negedge sys_clk);
      #1 check($sformatf("initlow c%0d grant", c), 64'(grant_o), 64'(0));
    end
    sdr_init_done = 1'b1;
    @(negedge sys_clk);
    #1 check("initrise grant", 64'(grant_o), 64'(2'b01));

    // Asynchronous reset in the middle of a transfer with ack present
    wb_ack_i = 1'b1;
    #1 check("prerst ack", 64'(m_ack_o), 64'(2'b01));
    #2 RESETN = 1'b0;
    #1 check_all_zero("async rst");
    @(negedge sys_clk);
    wb_ack_i = 1'b0;
    m_cyc_i  = 2'b11;
    m_stb_i  = 2'b11;
    RESETN   = 1'b1;
    #1 check("postrst grant", 64'(grant_o), 64'(0));
    @(negedge sys_clk);
    #1 check("postrst m0 first", 64'(grant_o), 64'(2'b01));
    m_cyc_i = 2'b00;
    m_stb_i = 2'b00;
    repeat (3) @(negedge sys_clk);

`ifdef SDRAM_WB_ARB_TIMEOUT_EN
    begin
      int busy_cycles = 0;
      int err_at      = -1;
      logic cyc_at_err = 1'b1;
      m_cyc_i = 2'b01;
      m_stb_i = 2'b01;
      for (int c = 0; c < 40 && err_at < 0; c++) begin
        @(negedge sys_clk);
        #1;
        if (busy_o) busy_cycles++;
        if (m_err_o[0]) begin
          err_at     = busy_cycles;
          cyc_at_err = wb_cyc_o;
        end
      end
      check("timeout err cycle", 64'(err_at), 64'(16));
      check("timeout cyc drop", 64'(cyc_at_err), 64'(0));
      @(negedge sys_clk);
      #1 check("timeout gap grant", 64'(grant_o), 64'(0));
      m_cyc_i = 2'b00;
      m_stb_i = 2'b00;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_wb_arbiter.md
Name: sdram_wb_arbiter

Overview:
- Round-robin Wishbone arbiter that shares the single Wishbone slave port of the SDRAM controller between NUM_MASTERS requesters.
- Holds a grant for a whole WB cycle (single or incrementing burst) and blocks all grants until sdr_init_done is high.
- Sits between the system masters and the SDRAM controller's wb_* port, in the sys_clk domain.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8).
- DW, 32, data width; select width is DW/8.
- AW, 26, address width.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with the optional feature.

Ports:
- sys_clk  in  1  system clock.
- RESETN  in  1  asynchronous active-low reset.
- sdr_init_done  in  1  SDRAM initialisation complete.
- m_cyc_i  in  NUM_MASTERS  per-master cycle.
- m_stb_i  in  NUM_MASTERS  per-master strobe.
- m_we_i  in  NUM_MASTERS  per-master write enable (1 = write).
- m_addr_i  in  NUM_MASTERS*AW  packed addresses; master k occupies slice k.
- m_dat_i  in  NUM_MASTERS*DW  packed write data.
- m_sel_i  in  NUM_MASTERS*DW/8  packed byte enables.
- m_cti_i  in  NUM_MASTERS*3  packed cycle type.
- m_ack_o  out  NUM_MASTERS  per-master acknowledge.
- m_dat_o  out  DW  read data, broadcast to all masters.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  to the SDRAM controller.
- wb_addr_o  out  AW  to the SDRAM controller.
- wb_dat_o  out  DW  to the SDRAM controller.
- wb_sel_o  out  DW/8  to the SDRAM controller.
- wb_cti_o  out  3  to the SDRAM controller.
- wb_ack_i  in  1  from the SDRAM controller.
- wb_dat_i  in  DW  from the SDRAM controller.
- grant_o  out  NUM_MASTERS  one-hot current grant; all-zero when idle.
- busy_o  out  1  arbiter in BUSY state.

Behaviour:
- Clock, reset: one clock, sys_clk. RESETN is asynchronous and active-low.
- Reset values:
  - state = IDLE; grant_o = 0; busy_o = 0.
  - rr_ptr = NUM_MASTERS-1, so master 0 has first priority.
  - All wb_* outputs 0; m_ack_o = 0; m_dat_o = 0.
- FSM states:
  - IDLE: req[k] = m_cyc_i[k] & m_stb_i[k].
    - If sdr_init_done = 1 and any req[k] is set: select the first requester scanning rr_ptr+1 … rr_ptr+NUM_MASTERS, modulo NUM_MASTERS.
    - Register the grant, set rr_ptr = winner, go to BUSY.
    - Otherwise stay in IDLE.
  - BUSY: wb_* outputs are a combinational mux of the granted master's inputs.
    - wb_cyc_o = m_cyc_i[g]; wb_stb_o = m_stb_i[g].
    - m_ack_o[g] = wb_ack_i; all other acks are 0. m_dat_o = wb_dat_i.
    - When m_cyc_i[g] = 0, go to GAP.
  - GAP: one-cycle bus turnaround.
    - All wb_* outputs 0; grant_o = 0.
    - Go to IDLE unconditionally.
- Latency:
  - A request sampled in IDLE appears on wb_stb_o one cycle later.
  - Minimum request-to-request spacing between different masters is 3 cycles (BUSY exit, GAP, IDLE arbitration).
- Bursts:
  - The grant is held for the whole cycle, regardless of cti.
  - cti = 3'b010 is passed through unmodified, as is cti = 3'b111.
  - The master ends ownership only by dropping cyc.
- Ack with no grant (IDLE or GAP): ignored; no m_ack_o is asserted.
- Ack and cyc drop in the same cycle: the ack is delivered, then the FSM goes to GAP.
- sdr_init_done falling while BUSY: the current cycle completes; no new grant is issued until it rises again.
- Reset mid-transaction: all outputs clear immediately (asynchronous); no ack is generated.

Optional Feature:
- Macro: SDRAM_WB_ARB_TIMEOUT_EN.
- With the macro defined:
  - Add output m_err_o [NUM_MASTERS].
  - A counter runs while in BUSY with wb_stb_o = 1 and wb_ack_i = 0.
  - When the count reaches TIMEOUT_CYCLES: pulse m_err_o[g] for one cycle, force wb_cyc_o = wb_stb_o = 0, and go to GAP.
  - The counter clears on every ack and on every grant.
- Without the macro: m_err_o is absent and BUSY waits indefinitely.

Decomposition:
- Package sdram_wb_arb_pkg holds:
  - typedef arb_state_t {IDLE, BUSY, GAP};
  - the CTI constants CTI_CLASSIC = 3'b000, CTI_INCR = 3'b010, CTI_EOB = 3'b111;
  - the function next_rr(req, ptr).
- Sub-module rr_picker: combinational round-robin selector, inputs req and rr_ptr, outputs winner index and valid.

Test Plan:
- Single master, NUM_MASTERS = 2, sdr_init_done = 1: m0 writes addr 0x010, data 0xDEADBEEF, sel 4'hF -> wb_stb_o rises 1 cycle later; wb_addr_o = 0x010; m_ack_o = 2'b01 on the controller ack; grant_o returns to 0 after GAP.
- Init gating: sdr_init_done = 0 while m1 requests for 50 cycles -> no wb_stb_o and grant_o = 0; after sdr_init_done rises, grant_o = 2'b10 on the next cycle.
- Fairness: m0 and m1 both request continuously, each doing 4 single writes -> grant order m0, m1, m0, m1, …; no master granted twice in a row while the other is waiting.
- Burst hold: m1 issues a 4-beat read with cti 010, 010, 010, 111 while m0 is requesting -> grant_o stays 2'b10 across all 4 acks; m0 is granted only after m1 drops cyc plus the GAP cycle.
- Stray ack: wb_ack_i pulsed while IDLE -> m_ack_o stays 0.
- Reset and timeout:
  - RESETN low mid-burst -> all outputs 0 asynchronously, FSM in IDLE.
  - With SDRAM_WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 16, no ack -> m_err_o[g] pulses at cycle 16 and wb_cyc_o drops.
